bc_round_ctrl: RTL and testbench
================================

Name: bc_round_ctrl

Overview:
- Sequences one Bulls-and-Cows game round by round.
- Collects four BCD digits from the ten debounced digit keys and presents the packed guess to the strike/ball comparator.
- Samples the comparator result, counts attempts, and declares win or lose.
- Sits between the key inputs and the comparator; the LED and LCD blocks consume its latched result outputs.

Parameters:
- MAX_TRIES, 10, attempts allowed per game (1..15).
- RES_LAT, 1, cycles from the guess_valid pulse to sampling strike/ball (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- key  in  10  debounced, clk-synchronous digit key levels; bit n = digit n.
- start  in  1  level; its rising edge begins a new game.
- strike  in  4  comparator strike count, valid RES_LAT cycles after guess_valid.
- ball  in  4  comparator ball count, same timing as strike.
- guess  out  16  packed BCD; [15:12] = first digit entered, [3:0] = fourth.
- guess_valid  out  1  one-cycle pulse; guess is stable from this cycle until the next digit entry.
- digit_cnt  out  3  digits entered in the current round (0..4).
- attempts  out  4  completed rounds in this game.
- res_strike  out  4  latched strike of the last completed round.
- res_ball  out  4  latched ball of the last completed round.
- res_valid  out  1  high while res_* hold a result from this game.
- dup_err  out  1  one-cycle pulse when a key press is rejected.
- win  out  1  level; game won.
- lose  out  1  level; tries exhausted without a win.

Behaviour:
- Reset values: state IDLE; guess, digit_cnt, attempts, res_*, res_valid all 0; all pulses 0; win = lose = 0.
- Edge detection: register key and start. A press is a rising edge on exactly one key bit in a cycle. Rising edges on two or more bits in the same cycle are ignored and give no dup_err.
- IDLE: start edge → ENTRY; clear guess, digit_cnt, attempts, res_valid.
- ENTRY, valid press of digit d:
  - write d into slot digit_cnt (slot 0 = [15:12]);
  - increment digit_cnt;
  - when digit_cnt reaches 4, go to CHECK on the next cycle.
- CHECK: assert guess_valid for one cycle, then wait RES_LAT cycles in WAIT. Key presses in CHECK/WAIT are ignored.
- WAIT end: latch strike/ball into res_*, set res_valid, increment attempts, then:
  - strike == 4 → WIN;
  - else attempts (post-increment) == MAX_TRIES → LOSE;
  - else → ENTRY with digit_cnt = 0. guess keeps its old value until the first new digit is written.
- WIN/LOSE: win/lose held high; keys ignored; a start edge → restart exactly as from IDLE.
- A start edge in ENTRY, CHECK or WAIT aborts the round and restarts; a pending comparator result is discarded.
- A key edge and a start edge in the same cycle: start wins, the key is dropped.
- attempts saturates at 15. MAX_TRIES > 15 is a parameter error.
- rst mid-round returns to the reset values on the next clk edge.

Optional Feature:
- Macro: BC_DUP_REJECT_EN.
- Defined: in ENTRY, a digit already present in slots 0..digit_cnt-1 is rejected. Rejection pulses dup_err and leaves guess and digit_cnt unchanged.
- Undefined: duplicates are accepted and dup_err is tied to 0.

Decomposition:
- Package bc_pkg holds:
  - the state enum (IDLE, ENTRY, CHECK, WAIT, WIN, LOSE);
  - NUM_DIGITS = 4, BCD_W = 4;
  - the one-hot-to-BCD encode function.
- One sub-module: bc_key_edge. It registers key/start, produces the single-press strobe plus 4-bit BCD code, and produces the start edge.

Test Plan:
- Reset, start, presses 1,2,3,4 → guess = 16'h1234, one guess_valid pulse; comparator returns strike = 4 → res_strike = 4, attempts = 1, win = 1.
- With the macro defined, presses 5,5,6,7,8 → one dup_err pulse on the second 5; final guess = 16'h5678, digit_cnt sequence 1,1,2,3,4.
- Keys 3 and 7 rising in the same cycle → no digit entered, no dup_err; the next single press of 9 → slot 0 = 9.
- MAX_TRIES = 2, two rounds with strike = 1 and ball = 2 → after the second round lose = 1, attempts = 2, res_ball = 2; further key presses are ignored.
- Start edge after 2 digits entered → digit_cnt = 0, attempts = 0, res_valid = 0, state ENTRY.
- rst asserted during WAIT → the next cycle shows all outputs at reset values and the late comparator result is not latched.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls-and-Cows round controller.
// BC_DUP_REJECT_EN (optional, see bc_round_ctrl) does not affect this package.
package bc_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int NUM_KEYS   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_e;

  // Only meaningful for a one-hot input; the highest set bit wins otherwise.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] oh);
    logic [BCD_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) code = BCD_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/bc_key_edge.sv
// Key/start edge detector: single-key press strobe with BCD code, and start edge.
// BC_DUP_REJECT_EN (optional, see bc_round_ctrl) does not affect this module.
module bc_key_edge
  import bc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic                start_i,
  output logic                press_o,
  output logic [BCD_W-1:0]    digit_o,
  output logic                start_edge_o
);

  logic [NUM_KEYS-1:0] key_q;
  logic                start_q;
  logic [NUM_KEYS-1:0] rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q   <= '0;
      start_q <= 1'b0;
    end else begin
      key_q   <= key_i;
      start_q <= start_i;
    end
  end

  assign rise = key_i & ~key_q;

  // Two or more keys rising together is treated as no press at all.
  assign press_o      = $onehot(rise);
  assign digit_o      = onehot_to_bcd(rise);
  assign start_edge_o = start_i & ~start_q;

endmodule

// File: rtl/bc_round_ctrl.sv
// Bulls-and-Cows round sequencer: digit entry, guess hand-off, result latch, win/lose.
// Optional macro BC_DUP_REJECT_EN: reject digits already present in the current guess.
//
// state | meaning
// IDLE  | no game since reset
// ENTRY | collecting digits of the current round
// CHECK | guess complete, guess_valid pulse
// WAIT  | waiting RES_LAT cycles for the comparator result
// WIN   | four strikes seen, holding win
// LOSE  | tries exhausted, holding lose
module bc_round_ctrl
  import bc_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int RES_LAT   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_KEYS-1:0]         key_i,
  input  logic                        start_i,
  input  logic [3:0]                  strike_i,
  input  logic [3:0]                  ball_i,
  output logic [NUM_DIGITS*BCD_W-1:0] guess_o,
  output logic                        guess_valid_o,
  output logic [2:0]                  digit_cnt_o,
  output logic [3:0]                  attempts_o,
  output logic [3:0]                  res_strike_o,
  output logic [3:0]                  res_ball_o,
  output logic                        res_valid_o,
  output logic                        dup_err_o,
  output logic                        win_o,
  output logic                        lose_o
);

  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("bc_round_ctrl: MAX_TRIES must be in 1..15");
  end
  if (RES_LAT < 1 || RES_LAT > 3) begin : g_bad_res_lat
    $error("bc_round_ctrl: RES_LAT must be in 1..3");
  end

  localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);
  localparam logic [1:0] LAT_LOAD_C  = 2'(RES_LAT - 1);
  localparam logic [2:0] LAST_SLOT_C = 3'(NUM_DIGITS - 1);

  logic             press;
  logic [BCD_W-1:0] key_digit;
  logic             start_edge;

  bc_key_edge u_key_edge (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .key_i        (key_i),
    .start_i      (start_i),
    .press_o      (press),
    .digit_o      (key_digit),
    .start_edge_o (start_edge)
  );

  state_e                        state_q;
  logic [NUM_DIGITS*BCD_W-1:0]   guess_q, guess_d;
  logic [2:0]                    digit_cnt_q, digit_cnt_d;
  logic [3:0]                    attempts_q, attempts_d;
  logic [3:0]                    res_strike_q, res_ball_q;
  logic                          res_valid_q;
  logic                          guess_valid_q;
  logic                          dup_err_q;
  logic                          win_q, lose_q;
  logic [1:0]                    lat_cnt_q;
  logic                          dup_hit;

  // Slot n lives at the n-th nibble from the top of the packed guess.
  always_comb begin
    guess_d = guess_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_cnt_q == 3'(i)) guess_d[(NUM_DIGITS-1-i)*BCD_W +: BCD_W] = key_digit;
    end
  end

  assign digit_cnt_d = digit_cnt_q + 3'd1;
  assign attempts_d  = (attempts_q == 4'hF) ? attempts_q : attempts_q + 4'd1;

`ifdef BC_DUP_REJECT_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((3'(i) < digit_cnt_q) &&
          (guess_q[(NUM_DIGITS-1-i)*BCD_W +: BCD_W] == key_digit)) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      guess_q       <= '0;
      digit_cnt_q   <= '0;
      attempts_q    <= '0;
      res_strike_q  <= '0;
      res_ball_q    <= '0;
      res_valid_q   <= 1'b0;
      guess_valid_q <= 1'b0;
      dup_err_q     <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      lat_cnt_q     <= '0;
    end else begin
      guess_valid_q <= 1'b0;
      dup_err_q     <= 1'b0;
      // A start edge overrides everything, including a key edge in the same cycle.
      if (start_edge) begin
        state_q     <= ENTRY;
        guess_q     <= '0;
        digit_cnt_q <= '0;
        attempts_q  <= '0;
        res_valid_q <= 1'b0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
        lat_cnt_q   <= '0;
      end else begin
        case (state_q)
          ENTRY: begin
            if (press) begin
              if (dup_hit) begin
                dup_err_q <= 1'b1;
              end else begin
                guess_q     <= guess_d;
                digit_cnt_q <= digit_cnt_d;
                if (digit_cnt_q == LAST_SLOT_C) begin
                  state_q       <= CHECK;
                  guess_valid_q <= 1'b1;
                end
              end
            end
          end
          CHECK: begin
            state_q   <= WAIT;
            lat_cnt_q <= LAT_LOAD_C;
          end
          WAIT: begin
            if (lat_cnt_q != 2'd0) begin
              lat_cnt_q <= lat_cnt_q - 2'd1;
            end else begin
              res_strike_q <= strike_i;
              res_ball_q   <= ball_i;
              res_valid_q  <= 1'b1;
              attempts_q   <= attempts_d;
              if (strike_i == 4'd4) begin
                state_q <= WIN;
                win_q   <= 1'b1;
              end else if (attempts_d == MAX_TRIES_C) begin
                state_q <= LOSE;
                lose_q  <= 1'b1;
              end else begin
                state_q     <= ENTRY;
                digit_cnt_q <= '0;
              end
            end
          end
          IDLE, WIN, LOSE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign guess_o       = guess_q;
  assign guess_valid_o = guess_valid_q;
  assign digit_cnt_o   = digit_cnt_q;
  assign attempts_o    = attempts_q;
  assign res_strike_o  = res_strike_q;
  assign res_ball_o    = res_ball_q;
  assign res_valid_o   = res_valid_q;
  assign dup_err_o     = dup_err_q;
  assign win_o         = win_q;
  assign lose_o        = lose_q;

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Self-checking bench for bc_round_ctrl: game-level model plus directed literal checks.
// Expectations follow BC_DUP_REJECT_EN when it is defined for the build.
module tb_bc_round_ctrl;

  localparam int MAX_T = 2;
  localparam int RLAT  = 2;
`ifdef BC_DUP_REJECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [9:0]  key_i = '0;
  logic        start_i = 1'b0;
  logic [3:0]  strike_i = 4'hE;
  logic [3:0]  ball_i = 4'hD;
  logic [15:0] guess_o;
  logic        guess_valid_o;
  logic [2:0]  digit_cnt_o;
  logic [3:0]  attempts_o, res_strike_o, res_ball_o;
  logic        res_valid_o, dup_err_o, win_o, lose_o;

  always #5 clk = ~clk;

  bc_round_ctrl #(.MAX_TRIES(MAX_T), .RES_LAT(RLAT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .key_i         (key_i),
    .start_i       (start_i),
    .strike_i      (strike_i),
    .ball_i        (ball_i),
    .guess_o       (guess_o),
    .guess_valid_o (guess_valid_o),
    .digit_cnt_o   (digit_cnt_o),
    .attempts_o    (attempts_o),
    .res_strike_o  (res_strike_o),
    .res_ball_o    (res_ball_o),
    .res_valid_o   (res_valid_o),
    .dup_err_o     (dup_err_o),
    .win_o         (win_o),
    .lose_o        (lose_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int gv_cnt = 0;
  int dup_cnt = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Comparator stand-in: the real answer is on the bus only in the sampling cycle.
  logic [3:0] cmp_s = 4'd0, cmp_b = 4'd0;
  int lat_cnt = -1;
  always @(posedge clk) begin
    #1;
    if (guess_valid_o) lat_cnt = RLAT;
    else if (lat_cnt >= 0) lat_cnt = lat_cnt - 1;
    if (lat_cnt == 0) begin
      strike_i = cmp_s;
      ball_i   = cmp_b;
    end else begin
      strike_i = 4'hE;
      ball_i   = 4'hD;
    end
  end

  // Game model: digits as a list, result due a fixed number of edges after the guess.
  bit          m_playing = 1'b0;
  int          m_digits[$];
  int          m_pend = 0;
  logic [15:0] m_guess = '0;
  bit          m_gv = 1'b0, m_dup = 1'b0, m_rv = 1'b0, m_won = 1'b0, m_lost = 1'b0;
  int          m_att = 0;
  logic [3:0]  m_rs = '0, m_rb = '0;
  logic [9:0]  m_pk = '0;
  bit          m_ps = 1'b0;

  always @(posedge clk) begin
    logic [9:0] rise;
    bit sedge, seen;
    int d, n;
    rise  = key_i & ~m_pk;
    sedge = start_i && !m_ps;
    m_pk  = rst_i ? 10'd0 : key_i;
    m_ps  = rst_i ? 1'b0 : start_i;
    m_gv  = 1'b0;
    m_dup = 1'b0;
    if (rst_i) begin
      m_playing = 0; m_digits.delete(); m_pend = 0; m_guess = '0; m_rv = 0;
      m_won = 0; m_lost = 0; m_att = 0; m_rs = '0; m_rb = '0;
    end else if (sedge) begin
      m_playing = 1; m_digits.delete(); m_pend = 0; m_guess = '0; m_rv = 0;
      m_won = 0; m_lost = 0; m_att = 0;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_rs = strike_i; m_rb = ball_i; m_rv = 1;
        m_att = (m_att < 15) ? m_att + 1 : 15;
        if (strike_i == 4'd4) begin m_won = 1; m_playing = 0; end
        else if (m_att == MAX_T) begin m_lost = 1; m_playing = 0; end
        else m_digits.delete();
      end
    end else if (m_playing && $countones(rise) == 1) begin
      d = 0;
      for (int i = 0; i < 10; i++) if (rise[i]) d = i;
      seen = 0;
      foreach (m_digits[i]) if (m_digits[i] == d) seen = 1;
      if (DUP_EN && seen) begin
        m_dup = 1;
      end else begin
        n = m_digits.size();
        m_guess[15-4*n -: 4] = 4'(d);
        m_digits.push_back(d);
        if (m_digits.size() == 4) begin m_gv = 1; m_pend = RLAT + 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("guess", guess_o, m_guess);
      chk("guess_valid", 16'(guess_valid_o), 16'(m_gv));
      chk("digit_cnt", 16'(digit_cnt_o), 16'(m_digits.size()));
      chk("attempts", 16'(attempts_o), 16'(m_att));
      chk("res_strike", 16'(res_strike_o), 16'(m_rs));
      chk("res_ball", 16'(res_ball_o), 16'(m_rb));
      chk("res_valid", 16'(res_valid_o), 16'(m_rv));
      chk("dup_err", 16'(dup_err_o), 16'(m_dup));
      chk("win", 16'(win_o), 16'(m_won));
      chk("lose", 16'(lose_o), 16'(m_lost));
      if (guess_valid_o) gv_cnt++;
      if (dup_err_o) dup_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int d);
    key_i = 10'(1) << d;
    cyc(2);
    key_i = '0;
    cyc(2);
  endtask

  task automatic start_game();
    start_i = 1'b1;
    cyc(2);
    start_i = 1'b0;
    cyc(1);
  endtask

  task automatic wait_att(input int target);
    int k;
    k = 0;
    while (attempts_o != 4'(target) && k < 30) begin
      cyc(1);
      k++;
    end
    chk("wait_attempts", 16'(attempts_o), 16'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    chk("rst_guess", guess_o, 16'h0000);
    chk("rst_win_lose", {14'd0, win_o, lose_o}, 16'd0);
    chk("rst_res_valid", 16'(res_valid_o), 16'd0);
    rst_i = 1'b0;
    cyc(2);

    // Game 1: 1,2,3,4 with four strikes -> win after one round.
    gv_cnt = 0;
    start_game();
    cmp_s = 4'd4; cmp_b = 4'd0;
    press(1); press(2); press(3); press(4);
    wait_att(1);
    cyc(2);
    chk("g1_guess", guess_o, 16'h1234);
    chk("g1_gv_pulses", 16'(gv_cnt), 16'd1);
    chk("g1_res_strike", 16'(res_strike_o), 16'd4);
    chk("g1_attempts", 16'(attempts_o), 16'd1);
    chk("g1_win", 16'(win_o), 16'd1);
    press(5);
    chk("g1_key_after_win", guess_o, 16'h1234);

    // Game 2: simultaneous keys ignored, then a normal round, then abort mid-entry.
    dup_cnt = 0;
    start_game();
    key_i = (10'(1) << 3) | (10'(1) << 7);
    cyc(2);
    key_i = '0;
    cyc(2);
    chk("g2_multi_cnt", 16'(digit_cnt_o), 16'd0);
    chk("g2_multi_dup", 16'(dup_cnt), 16'd0);
    press(9);
    chk("g2_slot0", guess_o, 16'h9000);
    chk("g2_cnt1", 16'(digit_cnt_o), 16'd1);
    cmp_s = 4'd1; cmp_b = 4'd2;
    press(1); press(3); press(4);
    wait_att(1);
    cyc(2);
    chk("g2_guess_kept", guess_o, 16'h9134);
    chk("g2_res", {8'd0, res_strike_o, res_ball_o}, 16'h0012);
    chk("g2_not_over", {14'd0, win_o, lose_o}, 16'd0);
    press(2);
    chk("g2_first_new", guess_o, 16'h2134);
    press(5);
    chk("g2_two_digits", guess_o, 16'h2534);
    start_game();
    chk("g2_abort_cnt", 16'(digit_cnt_o), 16'd0);
    chk("g2_abort_att", 16'(attempts_o), 16'd0);
    chk("g2_abort_rv", 16'(res_valid_o), 16'd0);

    // Game 3: duplicate handling, then exhaust MAX_T tries.
    dup_cnt = 0;
    press(5);
    chk("g3_cnt_a", 16'(digit_cnt_o), 16'd1);
    press(5);
`ifdef BC_DUP_REJECT_EN
    chk("g3_cnt_dup", 16'(digit_cnt_o), 16'd1);
    press(6); chk("g3_cnt_c", 16'(digit_cnt_o), 16'd2);
    press(7); chk("g3_cnt_d", 16'(digit_cnt_o), 16'd3);
    key_i = 10'(1) << 8;
    cyc(1);
    chk("g3_cnt_e", 16'(digit_cnt_o), 16'd4);
    chk("g3_guess", guess_o, 16'h5678);
    chk("g3_dup_pulses", 16'(dup_cnt), 16'd1);
    cyc(1);
    key_i = '0;
    cyc(2);
`else
    chk("g3_cnt_b", 16'(digit_cnt_o), 16'd2);
    press(6); press(7);
    chk("g3_guess", guess_o, 16'h5567);
    chk("g3_dup_pulses", 16'(dup_cnt), 16'd0);
    press(8);
`endif
    wait_att(1);
    cyc(2);
    press(1); press(2); press(3); press(4);
    wait_att(2);
    cyc(2);
    chk("g3_lose", 16'(lose_o), 16'd1);
    chk("g3_attempts", 16'(attempts_o), 16'd2);
    chk("g3_res_ball", 16'(res_ball_o), 16'd2);
    press(9); press(0);
    chk("g3_lose_held", {14'd0, win_o, lose_o}, 16'd1);
    chk("g3_att_held", 16'(attempts_o), 16'd2);

    // Game 4: reset while waiting for the comparator.
    start_game();
    cmp_s = 4'd4; cmp_b = 4'd0;
    press(1); press(2); press(3);
    key_i = 10'(1) << 4;
    begin
      int k;
      k = 0;
      do begin cyc(1); k++; end while (!guess_valid_o && k < 10);
      chk("g4_gv_seen", 16'(guess_valid_o), 16'd1);
    end
    key_i = '0;
    cyc(1);
    rst_i = 1'b1;
    cyc(1);
    chk("g4_rst_guess", guess_o, 16'h0000);
    chk("g4_rst_res", {8'd0, res_strike_o, res_ball_o}, 16'h0000);
    chk("g4_rst_flags", {11'd0, res_valid_o, guess_valid_o, dup_err_o, win_o, lose_o}, 16'd0);
    chk("g4_rst_cnts", {9'd0, digit_cnt_o, attempts_o}, 16'd0);
    rst_i = 1'b0;
    cyc(5);
    chk("g4_late_win", 16'(win_o), 16'd0);
    chk("g4_late_res", {11'd0, res_valid_o, res_strike_o}, 16'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
